// File: rtl/alu2_slice_sched.sv
// rtl/alu2_slice_sched.sv - round-robin scheduler sharing one 2-bit ALU slice across NREQ requesters
// Optional macro ALU2_SCHED_FIXED_PRIO_EN selects fixed lowest-index-wins arbitration.
module alu2_slice_sched #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*5-1:0]     req_ctl,
    input  logic [NREQ-1:0]       req_cin,
    output logic [NREQ-1:0]       gnt,
    output logic [1:0]            alu_a,
    output logic [1:0]            alu_b,
    output logic [4:0]            alu_ctl,
    output logic                  alu_cin,
    input  logic [1:0]            alu_f,
    input  logic                  alu_cout,
    input  logic [2:0]            alu_stat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_cout,
    output logic                  rsp_zero,
    output logic                  busy
);
    localparam int NDIG = WIDTH / 2;
    localparam int CW   = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [4:0]         r_ctl;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic [CW-1:0]      r_cnt;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     w_winner;
    logic               w_any;
    logic [WIDTH-1:0]   w_result_next;
    logic               w_unused_stat;

    assign w_unused_stat = ^alu_stat;
    assign w_any         = |req;

`ifdef ALU2_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w_winner = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] r_ptr;

    // Walk offsets from farthest to nearest so the last hit is the one closest after r_ptr.
    always_comb begin
        w_winner = '0;
        for (int off = NREQ; off >= 1; off--) begin
            if (req[(int'(r_ptr) + off) % NREQ]) w_winner = IDW'((int'(r_ptr) + off) % NREQ);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= w_winner;
        end
    end
`endif

    // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
    always_comb begin
        w_result_next = r_result >> 2;
        w_result_next[WIDTH-1 -: 2] = alu_f;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[w_winner*WIDTH +: WIDTH];
                        r_b     <= req_b[w_winner*WIDTH +: WIDTH];
                        r_ctl   <= req_ctl[w_winner*5 +: 5];
                        r_carry <= req_cin[w_winner];
                        r_id    <= w_winner;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> 2;
                    r_b      <= r_b >> 2;
                    r_result <= w_result_next;
                    r_carry  <= alu_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NDIG - 1)) r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt        = (rst_n && r_state == S_IDLE && w_any) ? (NREQ'(1) << w_winner) : '0;
    assign alu_a      = (r_state == S_RUN) ? r_a[1:0] : 2'b00;
    assign alu_b      = (r_state == S_RUN) ? r_b[1:0] : 2'b00;
    assign alu_ctl    = (r_state == S_RUN) ? r_ctl : 5'd0;
    assign alu_cin    = (r_state == S_RUN) ? r_carry : 1'b0;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_cout   = r_carry;
    assign rsp_zero   = (r_result == '0);
    assign busy       = (r_state != S_IDLE);
endmodule
